seq_alu_core: RTL and testbench
===============================

// Module: seq_alu_core
// PURPOSE
//  Operand-in ALU feeding the result/flag register stage. Computes a 2N-bit result and 4 status flags.
//  Handles 1-cycle logic/arith ops and multi-cycle shift-add multiply and restoring divide.
//  Uses a start/busy/done handshake to the control FSM.
//  Outputs change only on posedge clk, so they are stable when the downstream register samples on negedge.
// PARAMETERS
//  N   4   operand width; result width is 2N; multi-cycle ops iterate N times
// PORTS
//  clk     in   1    clock, posedge
//  rst     in   1    reset; asynchronous, active-high
//  start   in   1    launch op; sampled only in IDLE
//  op      in   3    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV
//  a       in   N    operand A (unsigned; two's complement for V flag)
//  b       in   N    operand B
//  busy    out  1    high while an op is in progress (CALC)
//  done    out  1    1-cycle pulse: result/flags valid from this edge
//  result  out  2N   held until the next done
//  flags   out  4    [3]=N [2]=Z [1]=C [0]=V; held with result
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, flags=0, internal accumulators=0.
//  FSM IDLE->(start & 1-cycle op)->DONE; IDLE->(start & MUL/DIV)->CALC->(count==N-1)->DONE; DONE->IDLE.
//  op, a and b are latched at the start edge; input changes afterwards have no effect.
//  start while busy or in DONE is ignored. No queuing.
//  Latency: 1-cycle ops assert done on the edge after start. MUL/DIV assert done N+1 edges after start.
//  busy=1 only in CALC. done=1 only in DONE.
//  ADD/SUB/logic/SHL: result={N'b0, r[N-1:0]}; N flag=r[N-1].
//    ADD: C=carry out; V=signed overflow.
//    SUB: r=a-b; C=borrow (a<b unsigned); V=signed overflow.
//    AND/OR/XOR: C=V=0.
//    SHL: r=a<<b[log2N-1:0]; C=last bit shifted out (0 if shift=0); V=0.
//  MUL: unsigned a*b, full 2N product; N flag=result[2N-1]; C=|result[2N-1:N]; V=0.
//  DIV: restoring, N iterations; result={remainder[N-1:0], quotient[N-1:0]}; N flag=result[2N-1]; C=V=0.
//  DIV by zero (b==0): skip CALC, 1-cycle; result={2N{1'b1}}, flags N=1, Z=0, C=0, V=1.
//  Z flag = (result==0) for all ops.
//  Reset mid-CALC: abort immediately to IDLE; no done; result/flags cleared.
//  result/flags update only in the cycle done rises; otherwise hold.
// CONFIGURATION
//  SEQ_ALU_DIV_EN defined: DIV (op 111) implemented as above.
//  SEQ_ALU_DIV_EN undefined: no divider logic. Op 111 completes in 1 cycle with result=0 and flags Z=1, V=1.
// TESTING
//  N=4. ADD a=F b=1 -> done 1 edge after start; result=8'h00, flags=4'b0110.
//  N=4. ADD a=7 b=1 -> result=8'h08, flags=4'b1001.
//  N=4. SUB a=3 b=5 -> result=8'h0E, flags=4'b1010.
//  N=4. MUL a=F b=F -> busy for 4 cycles, done on edge 5; result=8'hE1, flags=4'b1010.
//       start pulsed mid-op is ignored.
//  N=4. DIV a=D b=4 -> result=8'h13, flags=4'b0000.
//       DIV a=D b=0 -> 1-cycle; result=8'hFF, flags=4'b1001.
//       Without SEQ_ALU_DIV_EN: op 111 -> result=8'h00, flags=4'b0101.
//  N=4. Assert rst during MUL cycle 2 -> busy=0, done never pulses, result/flags=0.
//       Next ADD a=1 b=1 -> result=8'h02, flags=4'b0000.

Source files
------------

// File: rtl/seq_alu_core.sv
// Sequential ALU: 1-cycle add/sub/logic/shift, N-cycle shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op 111 completes at once with Z=V=1.
module seq_alu_core #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic [3:0]     flags
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCount = CW'(N - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpDiv = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e         state;
    logic [2*N-1:0] acc;
    logic [N-1:0]   opnd;
    logic [CW-1:0]  count;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated straight off the input operands
    // ------------------------------------------------------------------
    logic [N-1:0]   one_r;
    logic           one_c;
    logic           one_v;
    logic [N:0]     sum_ext;
    logic [N:0]     shl_ext;
    logic [2*N-1:0] one_res;
    logic [3:0]     one_flags;

    always_comb begin
        one_r     = '0;
        one_c     = 1'b0;
        one_v     = 1'b0;
        sum_ext   = '0;
        shl_ext   = '0;
        case (op)
            OpAdd: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                one_r   = sum_ext[N-1:0];
                one_c   = sum_ext[N];
                one_v   = (a[N-1] == b[N-1]) && (one_r[N-1] != a[N-1]);
            end
            OpSub: begin
                one_r = a - b;
                one_c = (a < b);
                one_v = (a[N-1] != b[N-1]) && (one_r[N-1] != a[N-1]);
            end
            OpAnd: one_r = a & b;
            OpOr:  one_r = a | b;
            OpXor: one_r = a ^ b;
            OpShl: begin
                // Bit N of the widened shift is the last bit pushed out (0 for shift 0).
                shl_ext = {1'b0, a} << b[SW-1:0];
                one_r   = shl_ext[N-1:0];
                one_c   = shl_ext[N];
            end
            default: ;
        endcase

        one_res   = {{N{1'b0}}, one_r};
        one_flags = {one_r[N-1], (one_r == '0), one_c, one_v};

        if (op == OpDiv) begin
`ifdef SEQ_ALU_DIV_EN
            one_res   = '1;
            one_flags = 4'b1001;
`else
            one_res   = '0;
            one_flags = 4'b0101;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle step: acc holds {hi, lo} for both multiply and divide
    // ------------------------------------------------------------------
    logic           start_multi;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [2*N-1:0] step_next;
    logic [3:0]     step_flags;

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[N-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic           is_div;
    logic [N:0]     div_trial;
    logic [2*N-1:0] div_next;

    // Restoring divide: {rem, quotient} shifts left; keep the trial subtraction if non-negative.
    always_comb begin
        div_trial = {acc[2*N-1:N], acc[N-1]} - {1'b0, opnd};
        if (!div_trial[N]) begin
            div_next = {div_trial[N-1:0], acc[N-2:0], 1'b1};
        end else begin
            div_next = {acc[2*N-2:0], 1'b0};
        end
    end

    assign start_multi = (op == OpMul) || ((op == OpDiv) && (b != '0));
    assign step_next   = is_div ? div_next : mul_next;
    assign step_flags  = {step_next[2*N-1], (step_next == '0),
                          !is_div && (step_next[2*N-1:N] != '0), 1'b0};
`else
    assign start_multi = (op == OpMul);
    assign step_next   = mul_next;
    assign step_flags  = {step_next[2*N-1], (step_next == '0),
                          (step_next[2*N-1:N] != '0), 1'b0};
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
            acc    <= '0;
            opnd   <= '0;
            count  <= '0;
`ifdef SEQ_ALU_DIV_EN
            is_div <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        if (start_multi) begin
                            state <= StCalc;
                            busy  <= 1'b1;
                            count <= '0;
                            // Multiply keeps multiplier in lo; divide keeps dividend in lo.
                            if (op == OpMul) begin
                                opnd <= a;
                                acc  <= {{N{1'b0}}, b};
                            end else begin
                                opnd <= b;
                                acc  <= {{N{1'b0}}, a};
                            end
`ifdef SEQ_ALU_DIV_EN
                            is_div <= (op == OpDiv);
`endif
                        end else begin
                            state  <= StDone;
                            done   <= 1'b1;
                            result <= one_res;
                            flags  <= one_flags;
                        end
                    end
                end
                StCalc: begin
                    acc   <= step_next;
                    count <= count + 1'b1;
                    if (count == LastCount) begin
                        state  <= StDone;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= step_next;
                        flags  <= step_flags;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core (N=4): driver pushes expectations, monitor checks on done.
module tb_seq_alu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] flags;

    seq_alu_core #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] flg;
        int         lat;
        int         nbusy;
        int         issue;
        int         busy_base;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_total = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) busy_total++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"}, 32'(result), 32'(e.res));
                        check({e.name, "_flags"}, 32'(flags), 32'(e.flg));
                        check({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
                        check({e.name, "_busy_cycles"}, 32'(busy_total - e.busy_base),
                              32'(e.nbusy));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Drive one op, scramble inputs right after the start edge, then let the monitor drain.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [3:0] x,
                          input logic [3:0] y, input logic [7:0] res, input logic [3:0] flg,
                          input int lat, input int nbusy, input bit poke_mid);
        exp_t e;
        int   t = 0;
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e.name = nm; e.res = res; e.flg = flg; e.lat = lat; e.nbusy = nbusy;
        e.issue = cyc; e.busy_base = busy_total;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        op    = o ^ 3'b011;
        if (poke_mid) begin
            @(negedge clk);
            @(negedge clk);
            op    = 3'b000;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (sb.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int dones;
        #2 rst = 1'b1;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("add_wrap",  3'b000, 4'hF, 4'h1, 8'h00, 4'b0110, 1, 0, 0);
        run_op("add_ovf",   3'b000, 4'h7, 4'h1, 8'h08, 4'b1001, 1, 0, 0);
        run_op("add_neg",   3'b000, 4'h8, 4'h8, 8'h00, 4'b0111, 1, 0, 0);
        run_op("sub_borrow",3'b001, 4'h3, 4'h5, 8'h0E, 4'b1010, 1, 0, 0);
        run_op("sub_ovf",   3'b001, 4'h8, 4'h1, 8'h07, 4'b0001, 1, 0, 0);
        run_op("and",       3'b010, 4'hC, 4'hA, 8'h08, 4'b1000, 1, 0, 0);
        run_op("or",        3'b011, 4'h5, 4'hA, 8'h0F, 4'b1000, 1, 0, 0);
        run_op("xor_zero",  3'b100, 4'h5, 4'h5, 8'h00, 4'b0100, 1, 0, 0);
        run_op("shl_2",     3'b101, 4'hB, 4'h2, 8'h0C, 4'b1000, 1, 0, 0);
        run_op("shl_1",     3'b101, 4'h9, 4'h1, 8'h02, 4'b0010, 1, 0, 0);
        run_op("shl_mask",  3'b101, 4'h9, 4'h5, 8'h02, 4'b0010, 1, 0, 0);
        run_op("shl_0",     3'b101, 4'h8, 4'h0, 8'h08, 4'b1000, 1, 0, 0);
        run_op("mul_ff",    3'b110, 4'hF, 4'hF, 8'hE1, 4'b1010, 5, 4, 1);
        run_op("mul_3x5",   3'b110, 4'h3, 4'h5, 8'h0F, 4'b0000, 5, 4, 0);
        run_op("mul_zero",  3'b110, 4'h0, 4'h7, 8'h00, 4'b0100, 5, 4, 0);
`ifdef SEQ_ALU_DIV_EN
        run_op("div_d4",    3'b111, 4'hD, 4'h4, 8'h13, 4'b0000, 5, 4, 0);
        run_op("div_73",    3'b111, 4'h7, 4'h3, 8'h12, 4'b0000, 5, 4, 0);
        run_op("div_zero",  3'b111, 4'hD, 4'h0, 8'hFF, 4'b1001, 1, 0, 0);
`else
        run_op("op7_a",     3'b111, 4'hD, 4'h4, 8'h00, 4'b0101, 1, 0, 0);
        run_op("op7_b",     3'b111, 4'hD, 4'h0, 8'h00, 4'b0101, 1, 0, 0);
`endif
        run_op("add_before_rst", 3'b000, 4'h6, 4'h3, 8'h09, 4'b1001, 1, 0, 0);

        // Abort a multiply in its second CALC cycle.
        wait_idle();
        op = 3'b110; a = 4'hF; b = 4'hF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_calc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("add_after_rst", 3'b000, 4'h1, 4'h1, 8'h02, 4'b0000, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
